// File: rtl/cc_cond_if.sv
// Bus bundle between the execute-stage datapath and the condition-code unit.
// master drives ALU results and control; slave (the unit) drives flags and Cnd.
interface cc_cond_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
);
  logic [DATA_W-1:0] valE_in;
  logic              of_in;
  logic              set_cc;
  logic              cc_hold;
  logic              cond_req;
  logic [3:0]        ifun;
  logic              zf;
  logic              sf;
  logic              of;
  logic              cnd;
  logic              cnd_err;
  logic              cc_valid;
  logic [CNT_W-1:0]  taken_cnt;

  modport master (
    output valE_in, of_in, set_cc, cc_hold, cond_req, ifun,
    input  zf, sf, of, cnd, cnd_err, cc_valid, taken_cnt
  );

  modport slave (
    input  valE_in, of_in, set_cc, cc_hold, cond_req, ifun,
    output zf, sf, of, cnd, cnd_err, cc_valid, taken_cnt
  );
endinterface

// File: rtl/cc_cond_unit.sv
// Condition-code register and jXX/cmovXX evaluator for the execute stage.
// Define CC_STATS_EN to build the saturating taken-condition counter.
module cc_cond_unit #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic     clk,
  input  logic     reset,
  cc_cond_if.slave bus
);

  logic zf_q, zf_d;
  logic sf_q, sf_d;
  logic of_q, of_d;
  logic cc_valid_q, cc_valid_d;
  logic cnd_c, cnd_err_c;
  logic lt_c;

  always_comb begin
    zf_d       = zf_q;
    sf_d       = sf_q;
    of_d       = of_q;
    cc_valid_d = cc_valid_q;
    if (bus.set_cc && !bus.cc_hold) begin
      zf_d       = (bus.valE_in == '0);
      sf_d       = bus.valE_in[DATA_W-1];
      of_d       = bus.of_in;
      cc_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zf_q       <= 1'b1;
      sf_q       <= 1'b0;
      of_q       <= 1'b0;
      cc_valid_q <= 1'b0;
    end else begin
      zf_q       <= zf_d;
      sf_q       <= sf_d;
      of_q       <= of_d;
      cc_valid_q <= cc_valid_d;
    end
  end

  // Evaluated only from stored flags so a same-cycle set_cc sees pre-update values.
  assign lt_c = sf_q ^ of_q;

  always_comb begin
    cnd_c     = 1'b0;
    cnd_err_c = 1'b0;
    if (bus.cond_req) begin
      case (bus.ifun)
        4'd0:    cnd_c = 1'b1;
        4'd1:    cnd_c = lt_c | zf_q;
        4'd2:    cnd_c = lt_c;
        4'd3:    cnd_c = zf_q;
        4'd4:    cnd_c = ~zf_q;
        4'd5:    cnd_c = ~lt_c;
        4'd6:    cnd_c = ~lt_c & ~zf_q;
        default: cnd_err_c = 1'b1;
      endcase
    end
  end

  assign bus.zf       = zf_q;
  assign bus.sf       = sf_q;
  assign bus.of       = of_q;
  assign bus.cc_valid = cc_valid_q;
  assign bus.cnd      = cnd_c;
  assign bus.cnd_err  = cnd_err_c;

`ifdef CC_STATS_EN
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    taken_cnt_d = taken_cnt_q;
    if (bus.cond_req && cnd_c && (taken_cnt_q != {CNT_W{1'b1}})) begin
      taken_cnt_d = taken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt_q <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign bus.taken_cnt = taken_cnt_q;
`else
  assign bus.taken_cnt = '0;
`endif

endmodule

// File: tb/tb_cc_cond_unit.sv
// Scoreboard bench for cc_cond_unit: directed plan vectors followed by random traffic.
// A reference model predicts every output; a negedge monitor pops and compares.
module tb_cc_cond_unit;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic       zf, sf, of, cnd, cnd_err, cc_valid;
    int         cnt;
    logic [3:0] ifun;
    logic       req;
  } exp_t;

  logic clk;
  logic reset;
  cc_cond_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  cc_cond_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  // Reference model state: the flags describe the last recorded comparison result.
  bit   m_known;
  bit   m_zf, m_sf, m_of, m_valid;
  int   m_cnt;

  // Conditions phrased as relations of the last result to zero.
  function automatic bit [1:0] model_cond(bit req, bit [3:0] f, bit z, bit s, bit o);
    bit less, equal;
    less  = (s != o);
    equal = z;
    if (!req) return 2'b00;
    if (f > 4'd6) return 2'b10;
    case (f)
      4'd0: return {1'b0, 1'b1};
      4'd1: return {1'b0, less || equal};
      4'd2: return {1'b0, less};
      4'd3: return {1'b0, equal};
      4'd4: return {1'b0, !equal};
      4'd5: return {1'b0, !less};
      default: return {1'b0, !less && !equal};
    endcase
  endfunction

  task automatic step(input bit rst, input logic [DATA_W-1:0] v, input bit ofi,
                      input bit set, input bit hold, input bit req, input bit [3:0] f);
    bit [1:0] r;
    exp_t e;
    @(posedge clk);
    // Advance the model with the inputs that were present at this edge.
    if (reset) begin
      m_known = 1; m_zf = 1; m_sf = 0; m_of = 0; m_valid = 0; m_cnt = 0;
    end else if (m_known) begin
      r = model_cond(bus.cond_req, bus.ifun, m_zf, m_sf, m_of);
`ifdef CC_STATS_EN
      if (r[0] && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
`endif
      if (bus.set_cc && !bus.cc_hold) begin
        m_zf = (bus.valE_in == 0);
        m_sf = bus.valE_in[DATA_W-1];
        m_of = bus.of_in;
        m_valid = 1;
      end
    end
    #1;
    reset        = rst;
    bus.valE_in  = v;
    bus.of_in    = ofi;
    bus.set_cc   = set;
    bus.cc_hold  = hold;
    bus.cond_req = req;
    bus.ifun     = f;
    if (m_known) begin
      r = model_cond(req, f, m_zf, m_sf, m_of);
      e.zf = m_zf; e.sf = m_sf; e.of = m_of; e.cc_valid = m_valid;
      e.cnd = r[0]; e.cnd_err = r[1]; e.cnt = m_cnt; e.ifun = f; e.req = req;
      exp_q.push_back(e);
    end
  endtask

  task automatic chk(input string name, input int act, input int req_v);
    if (act != req_v) begin
      miscompares++;
      $display("FAIL %s vec=%0d got=%0d want=%0d", name, vectors, act, req_v);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, compare once per presented vector.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      chk("zf",       int'(bus.zf),       int'(e.zf));
      chk("sf",       int'(bus.sf),       int'(e.sf));
      chk("of",       int'(bus.of),       int'(e.of));
      chk("cc_valid", int'(bus.cc_valid), int'(e.cc_valid));
      chk("cnd",      int'(bus.cnd),      int'(e.cnd));
      chk("cnd_err",  int'(bus.cnd_err),  int'(e.cnd_err));
      chk("taken_cnt", int'(bus.taken_cnt), e.cnt);
      if ($isunknown({bus.zf, bus.sf, bus.of, bus.cnd, bus.cnd_err, bus.cc_valid})) begin
        miscompares++;
        $display("FAIL xcheck vec=%0d got=X want=defined", vectors);
      end
      $display("vec %0d req=%0b ifun=%0d zf=%0b sf=%0b of=%0b cnd=%0b err=%0b cnt=%0d",
               vectors, e.req, e.ifun, bus.zf, bus.sf, bus.of, bus.cnd, bus.cnd_err,
               bus.taken_cnt);
    end
  end

  initial begin
    logic [DATA_W-1:0] v;
    int sel;
    vectors = 0; miscompares = 0; m_known = 0;
    m_zf = 0; m_sf = 0; m_of = 0; m_valid = 0; m_cnt = 0;
    reset = 1; bus.valE_in = '0; bus.of_in = 0; bus.set_cc = 0;
    bus.cc_hold = 0; bus.cond_req = 0; bus.ifun = '0;

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 3);                 // post-reset zf=1 -> e true
    step(0, 64'h8000000000000000, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 1, 5);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0, 0, 0);                 // zf <= 1
    step(0, 5, 0, 1, 1, 0, 0);                 // held update dropped
    step(0, 0, 0, 0, 0, 1, 4);
    step(0, 7, 0, 1, 0, 1, 3);                 // same-cycle set and evaluate
    step(0, 0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 1, 9);
    step(0, 0, 0, 0, 0, 0, 9);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 1, 0);  // drive counter to saturation
    step(1, 7, 1, 1, 0, 1, 0);                 // reset beats set_cc
    step(0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 500; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       v = '0;
        1:       v = {1'b1, 31'($urandom), 32'($urandom)};
        2:       v = DATA_W'($urandom_range(1, 9));
        default: v = {32'($urandom), 32'($urandom)};
      endcase
      step(($urandom_range(0, 24) == 0), v, 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
           (($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 6))));
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
